// File: rtl/f32_acc_if.sv
// Handshake bundle for the binary32 accumulator: a term stream in, a sum stream out.
// The master side feeds terms and drains sums; the slave side is the accumulator.
`timescale 1ns/1ps
interface f32_acc_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_count;

  modport master (output in_data, in_valid, in_last, out_ready,
                  input  in_ready, out_data, out_valid, out_count);
  modport slave  (input  in_data, in_valid, in_last, out_ready,
                  output in_ready, out_data, out_valid, out_count);
endinterface

// File: rtl/f32_acc.sv
// Sequential binary32 accumulator: each term passes through align/add/normalize/round
// states, and the running sum is emitted when the term flagged as last has been folded in.
`timescale 1ns/1ps
module f32_acc (
  input  logic     clk,
  input  logic     rst,
  f32_acc_if.slave bus
);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, OUT} state_t;
  state_t state_reg;

  logic [31:0]       acc_reg, term_reg, special_val_reg, out_data_reg;
  logic              empty_reg, nan_reg, last_reg, special_reg, sub_reg, sign_reg, zero_reg;
  logic              in_ready_reg, out_valid_reg;
  logic [15:0]       count_reg;
  logic [26:0]       big_sig_reg, small_sig_reg, norm_sig_reg;
  logic [27:0]       sum_reg;
  logic [7:0]        exp_reg;
  logic signed [9:0] norm_exp_reg;

  // Operand fields: a is the running sum, b the incoming (already flushed) term.
  logic        a_s, b_s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_big;
  logic [7:0]  a_e, b_e, big_e, small_e, diff;
  logic [22:0] a_f, b_f;
  logic [23:0] big_m, small_m;
  logic        big_s;
  logic [26:0] small_ext, shifted, lost_mask, aligned;
  logic        nan_hit, spec_hit;
  logic [31:0] spec_val;

  assign {a_s, a_e, a_f} = acc_reg;
  assign {b_s, b_e, b_f} = term_reg;
  assign a_nan  = (a_e == 8'hFF) && (a_f != 23'd0);
  assign b_nan  = (b_e == 8'hFF) && (b_f != 23'd0);
  assign a_inf  = (a_e == 8'hFF) && (a_f == 23'd0);
  assign b_inf  = (b_e == 8'hFF) && (b_f == 23'd0);
  assign a_zero = (a_e == 8'd0);
  assign b_zero = (b_e == 8'd0);
  assign a_big  = {a_e, a_f} >= {b_e, b_f};

  always_comb begin
    big_e     = a_big ? a_e : b_e;
    small_e   = a_big ? b_e : a_e;
    big_m     = a_big ? {1'b1, a_f} : {1'b1, b_f};
    small_m   = a_big ? {1'b1, b_f} : {1'b1, a_f};
    big_s     = a_big ? a_s : b_s;
    diff      = big_e - small_e;
    small_ext = {small_m, 3'b000};
    shifted   = small_ext >> diff;
    lost_mask = ~(27'h7FF_FFFF << diff);
    // Beyond 25 positions every significand bit lands below the sticky position.
    if (diff >= 8'd26)
      aligned = 27'd1;
    else
      aligned = {shifted[26:1], shifted[0] | (|(small_ext & lost_mask))};
  end

  // Specials and the first-term load bypass the arithmetic datapath entirely.
  always_comb begin
    nan_hit  = b_nan | a_nan | (a_inf & b_inf & (a_s ^ b_s));
    spec_hit = 1'b1;
    spec_val = QNAN;
    if (nan_hit)              spec_val = QNAN;
    else if (empty_reg)       spec_val = term_reg;
    else if (a_inf)           spec_val = acc_reg;
    else if (b_inf)           spec_val = term_reg;
    else if (a_zero & b_zero) spec_val = {a_s & b_s, 31'd0};
    else if (a_zero)          spec_val = term_reg;
    else if (b_zero)          spec_val = acc_reg;
    else                      spec_hit = 1'b0;
  end

  logic [4:0] lzc;
  always_comb begin
    lzc = 5'd0;
    for (int i = 0; i < 27; i++)
      if (sum_reg[i]) lzc = 5'(26 - i);
  end

  logic              rnd_up;
  logic [24:0]       rnd_sig;
  logic signed [9:0] rnd_exp;
  logic [22:0]       rnd_frac;
  logic [31:0]       round_val;

  always_comb begin
    rnd_up   = norm_sig_reg[2] & (norm_sig_reg[1] | norm_sig_reg[0] | norm_sig_reg[3]);
    rnd_sig  = {1'b0, norm_sig_reg[26:3]} + {24'd0, rnd_up};
    rnd_exp  = norm_exp_reg + $signed({9'd0, rnd_sig[24]});
    rnd_frac = rnd_sig[24] ? rnd_sig[23:1] : rnd_sig[22:0];
    if (nan_reg)                    round_val = QNAN;
    else if (special_reg)           round_val = special_val_reg;
    else if (zero_reg)              round_val = 32'h0000_0000;
    else if (rnd_exp >= 10'sd255)   round_val = {sign_reg, 8'hFF, 23'd0};
    else if (rnd_exp <= 10'sd0)     round_val = {sign_reg, 31'd0};
    else                            round_val = {sign_reg, rnd_exp[7:0], rnd_frac};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      in_ready_reg    <= 1'b0;
      out_valid_reg   <= 1'b0;
      out_data_reg    <= 32'd0;
      count_reg       <= 16'd0;
      acc_reg         <= 32'd0;
      empty_reg       <= 1'b1;
      nan_reg         <= 1'b0;
      term_reg        <= 32'd0;
      last_reg        <= 1'b0;
      special_reg     <= 1'b0;
      special_val_reg <= 32'd0;
      sub_reg         <= 1'b0;
      sign_reg        <= 1'b0;
      zero_reg        <= 1'b0;
      big_sig_reg     <= 27'd0;
      small_sig_reg   <= 27'd0;
      norm_sig_reg    <= 27'd0;
      sum_reg         <= 28'd0;
      exp_reg         <= 8'd0;
      norm_exp_reg    <= 10'sd0;
    end else begin
      case (state_reg)
        IDLE: begin
          in_ready_reg <= 1'b1;
          if (bus.in_valid && in_ready_reg) begin
            term_reg     <= (bus.in_data[30:23] == 8'd0) ? {bus.in_data[31], 31'd0} : bus.in_data;
            last_reg     <= bus.in_last;
            if (count_reg != 16'hFFFF) count_reg <= count_reg + 16'd1;
            in_ready_reg <= 1'b0;
            state_reg    <= ALIGN;
          end
        end
        ALIGN: begin
          nan_reg         <= nan_reg | nan_hit;
          special_reg     <= spec_hit;
          special_val_reg <= spec_val;
          big_sig_reg     <= {big_m, 3'b000};
          small_sig_reg   <= aligned;
          exp_reg         <= big_e;
          sign_reg        <= big_s;
          sub_reg         <= a_s ^ b_s;
          state_reg       <= ADD;
        end
        ADD: begin
          sum_reg   <= sub_reg ? {1'b0, big_sig_reg} - {1'b0, small_sig_reg}
                               : {1'b0, big_sig_reg} + {1'b0, small_sig_reg};
          state_reg <= NORM;
        end
        NORM: begin
          if (sum_reg[27]) begin
            norm_sig_reg <= {sum_reg[27:2], sum_reg[1] | sum_reg[0]};
            norm_exp_reg <= $signed({2'b00, exp_reg}) + 10'sd1;
          end else begin
            norm_sig_reg <= sum_reg[26:0] << lzc;
            norm_exp_reg <= $signed({2'b00, exp_reg}) - $signed({5'd0, lzc});
          end
          zero_reg  <= (sum_reg == 28'd0);
          state_reg <= ROUND;
        end
        ROUND: begin
          acc_reg   <= round_val;
          empty_reg <= 1'b0;
          if (last_reg) begin
            out_data_reg  <= round_val;
            out_valid_reg <= 1'b1;
            state_reg     <= OUT;
          end else begin
            in_ready_reg <= 1'b1;
            state_reg    <= IDLE;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            acc_reg       <= 32'd0;
            empty_reg     <= 1'b1;
            nan_reg       <= 1'b0;
            count_reg     <= 16'd0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_count = count_reg;
endmodule

// File: tb/tb_f32_acc.sv
// Directed bench for f32_acc: a table of two-term sums plus hand-written sequences
// for backpressure and reset in the middle of an accumulation.
`timescale 1ns/1ps
module tb_f32_acc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  f32_acc_if bus();

  f32_acc dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        has_a;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_data;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs [15];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Waits (bounded) for in_ready, then presents one term for exactly one accepting edge.
  // Returns #1 after the accepting edge.
  task automatic send_term(input logic [31:0] d, input logic l);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout actual=0 required=1");
    end
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    bus.in_last  = l;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 32'h0;
  endtask

  // The accepting edge counts as edge 1; returns the edge number after which out_valid is seen.
  task automatic wait_out(output int edges);
    edges = 1;
    while (bus.out_valid !== 1'b1 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic wait_ready(output int edges);
    edges = 1;
    while (bus.in_ready !== 1'b1 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic [31:0] held;

    vecs[0]  = '{1'b1, 32'h3F800000, 32'h40000000, 32'h40400000, 16'd2};
    vecs[1]  = '{1'b1, 32'h3F800000, 32'hBF800000, 32'h00000000, 16'd2};
    vecs[2]  = '{1'b0, 32'h00000000, 32'h80000000, 32'h80000000, 16'd1};
    vecs[3]  = '{1'b1, 32'h3F800000, 32'h33800000, 32'h3F800000, 16'd2};
    vecs[4]  = '{1'b1, 32'h3F800000, 32'h33C00000, 32'h3F800001, 16'd2};
    vecs[5]  = '{1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 16'd2};
    vecs[6]  = '{1'b1, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 16'd2};
    vecs[7]  = '{1'b1, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 16'd2};
    vecs[8]  = '{1'b1, 32'h80000000, 32'h80000000, 32'h80000000, 16'd2};
    vecs[9]  = '{1'b0, 32'h00000000, 32'h00400000, 32'h00000000, 16'd1};
    vecs[10] = '{1'b1, 32'h7F800000, 32'h3F800000, 32'h7F800000, 16'd2};
    vecs[11] = '{1'b1, 32'h40400000, 32'hBF800000, 32'h40000000, 16'd2};
    vecs[12] = '{1'b1, 32'h3FC00000, 32'hBF800000, 32'h3F000000, 16'd2};
    vecs[13] = '{1'b1, 32'h3F800000, 32'h80400000, 32'h3F800000, 16'd2};
    vecs[14] = '{1'b1, 32'h00000000, 32'h80000000, 32'h00000000, 16'd2};

    bus.in_data   = 32'h0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    check32("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check32("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check32("rst_out_data", bus.out_data, 32'h0);
    check32("rst_out_count", {16'd0, bus.out_count}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check32("first_edge_in_ready", {31'd0, bus.in_ready}, 32'd1);
    $display("txn reset release: in_ready=%b", bus.in_ready);

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].has_a) send_term(vecs[i].a, 1'b0);
      send_term(vecs[i].b, 1'b1);
      wait_out(lat);
      check32($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
      check32($sformatf("vec%0d_data", i), bus.out_data, vecs[i].exp_data);
      check32($sformatf("vec%0d_count", i), {16'd0, bus.out_count}, {16'd0, vecs[i].exp_count});
      $display("txn vec%0d: a=%h b=%h -> out_data=%h out_count=%0d latency=%0d",
               i, vecs[i].a, vecs[i].b, bus.out_data, bus.out_count, lat);
      @(posedge clk); #1;
      check32($sformatf("vec%0d_out_valid_drop", i), {31'd0, bus.out_valid}, 32'd0);
    end

    // Backpressure on a three-term sum
    bus.out_ready = 1'b0;
    send_term(32'h3F800000, 1'b0);
    wait_ready(lat);
    check32("term_period", 32'(lat), 32'd5);
    send_term(32'h3F800000, 1'b0);
    send_term(32'h3F800000, 1'b1);
    wait_out(lat);
    check32("bp_latency", 32'(lat), 32'd5);
    check32("bp_data", bus.out_data, 32'h40400000);
    check32("bp_count", {16'd0, bus.out_count}, 32'd3);
    held = bus.out_data;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check32($sformatf("bp_hold%0d_valid", c), {31'd0, bus.out_valid}, 32'd1);
      check32($sformatf("bp_hold%0d_data", c), bus.out_data, held);
      check32($sformatf("bp_hold%0d_in_ready", c), {31'd0, bus.in_ready}, 32'd0);
    end
    $display("txn backpressure: held out_data=%h count=%0d for 10 cycles", bus.out_data, bus.out_count);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check32("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
    check32("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    send_term(32'h3F800000, 1'b1);
    wait_out(lat);
    check32("after_bp_data", bus.out_data, 32'h3F800000);
    check32("after_bp_count", {16'd0, bus.out_count}, 32'd1);
    $display("txn after backpressure: out_data=%h count=%0d", bus.out_data, bus.out_count);
    @(posedge clk); #1;

    // Reset while the third term is in the add step
    send_term(32'h3F800000, 1'b0);
    send_term(32'h3F800000, 1'b0);
    send_term(32'h40000000, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check32("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check32("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check32("midrst_out_data", bus.out_data, 32'h0);
    check32("midrst_out_count", {16'd0, bus.out_count}, 32'd0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check32("midrst_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check32("midrst_release_out_valid", {31'd0, bus.out_valid}, 32'd0);
    send_term(32'h40000000, 1'b1);
    wait_out(lat);
    check32("midrst_next_latency", 32'(lat), 32'd5);
    check32("midrst_next_data", bus.out_data, 32'h40000000);
    check32("midrst_next_count", {16'd0, bus.out_count}, 32'd1);
    $display("txn after mid-op reset: out_data=%h count=%0d", bus.out_data, bus.out_count);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/f32_acc.md
F32_ACC -- requirements
Module: f32_acc

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port in_data  input  32  IEEE-754 binary32 term, typically a product from the upstream f32 multiplier.
REQ-004 SHALL have port in_valid  input  1  in_data/in_last valid.
REQ-005 SHALL have port in_last  input  1  term is the final term of the current sum.
REQ-006 SHALL have port in_ready  output  1  block accepts a term this cycle.
REQ-007 SHALL have port out_data  output  32  binary32 accumulated sum.
REQ-008 SHALL have port out_valid  output  1  out_data valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-010 SHALL have port out_count  output  16  number of terms in the emitted sum, saturating at 0xFFFF.

Function
REQ-011 SHALL implement FSM states IDLE, ALIGN, ADD, NORM, ROUND, OUT.
REQ-012 SHALL drive in_ready=1 only in IDLE; a term is accepted on any edge with in_valid & in_ready.
REQ-013 SHALL advance IDLE->ALIGN->ADD->NORM->ROUND, one state per cycle, with no stalls.
REQ-014 After ROUND, SHALL go to OUT if the term carried in_last, otherwise to IDLE.
REQ-015 SHALL keep out_valid=1 throughout OUT; on out_valid & out_ready it SHALL return to IDLE, clear the accumulator to +0, set the empty flag, and clear the count.
REQ-016 Latency: out_valid SHALL rise exactly 5 edges after the edge accepting the last term; repeat throughput is 1 term per 5 cycles.
REQ-017 Inputs with biased exponent 0 SHALL be treated as signed zero, so subnormals flush to zero, matching the multiplier.
REQ-018 While the empty flag is set, the first term SHALL be loaded as-is (after flush) and the add SHALL be bypassed; it still passes through all four states.
REQ-019 ALIGN SHALL select the larger-magnitude operand and right-shift the smaller 24-bit significand (hidden bit included) by the exponent difference, keeping guard, round and OR-ed sticky bits; shifts of 26 or more SHALL leave only sticky.
REQ-020 ADD SHALL add or subtract significands (27-bit datapath plus carry) according to the sign XOR; the result sign is that of the larger magnitude.
REQ-021 NORM SHALL normalize in one cycle: right-shift 1 on carry (exp+1, sticky preserved); otherwise left-shift by a combinational leading-zero count (exp-lzc).
REQ-022 ROUND SHALL apply round-to-nearest-even; a significand carry-out SHALL increment the exponent.
REQ-023 An exponent at or above 255 after ROUND SHALL give signed infinity.
REQ-024 An exponent at or below 0 after ROUND SHALL give a zero carrying the result sign.
REQ-025 An exact cancellation SHALL give +0.
REQ-026 (-0)+(-0) SHALL give -0.
REQ-027 Any NaN operand, or +inf + -inf, SHALL give NaN = 0x7FC00000 and be sticky until OUT completes.
REQ-028 inf + finite SHALL give that inf.
REQ-029 out_data SHALL be registered and stable while out_valid=1.

Reset
REQ-030 While rst=1, at any time including mid-operation, SHALL force state IDLE, in_ready=0, out_valid=0, out_data=0x00000000, out_count=0, accumulator=+0, empty=1, NaN flag=0.
REQ-031 On the first edge after rst falls, SHALL drive in_ready=1.
REQ-032 A partially accumulated sum SHALL be discarded by reset and never emitted.

Verification
REQ-033 SHALL verify: 0x3F800000 then 0x40000000(last) -> out_data=0x40400000, out_count=2, out_valid 5 edges after the second accept.
REQ-034 SHALL verify: 0x3F800000 then 0xBF800000(last) -> 0x00000000; and 0x80000000(last) alone -> 0x80000000.
REQ-035 SHALL verify rounding: 0x3F800000+0x33800000(last) -> 0x3F800000 (tie to even); 0x3F800000+0x33C00000(last) -> 0x3F800001.
REQ-036 SHALL verify overflow/specials: 0x7F7FFFFF+0x7F7FFFFF(last) -> 0x7F800000; 0x7F800000+0xFF800000(last) -> 0x7FC00000; 0x7FC00001 then 0x3F800000(last) -> 0x7FC00000.
REQ-037 SHALL verify backpressure: hold out_ready=0 for 10 cycles -> out_valid and out_data stable and in_ready=0; then out_ready=1 -> IDLE next edge, and the next sum starts from +0.
REQ-038 SHALL verify reset mid-operation: assert rst in ADD after 3 accepted terms -> all outputs at reset values; a following single term 0x40000000(last) -> 0x40000000, out_count=1.
